partial_product_accumulator: RTL and testbench
==============================================

# partial_product_accumulator

Sequential shift-add stage that consumes 4-bit partial products and accumulates them into an 8-bit unsigned product. It latches operands A and B on a start request and walks B one bit per cycle. Each cycle it gates A with the current multiplier bit through a `partial_product` instance, shifts the result to its bit weight and adds it into a running sum. It sits directly downstream of the partial-product generator and forms the iterative, low-area counterpart of the parallel unsigned multiplier.

## Interface
- Parameters: none. Operand width is fixed at 4 and product width at 8, to match the `partial_product` generator.
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- Start  input  1  request to begin a multiply; sampled only in IDLE or DONE.
- A  input  4  multiplicand; captured on an accepted Start.
- B  input  4  multiplier; captured on an accepted Start.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse; Product is valid from this cycle.
- Product  output  8  accumulated unsigned product; holds its value until the next accepted Start.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: Start=1 → RUN.
  - RUN: bit counter = 3 → DONE.
  - DONE: Start=1 → RUN; otherwise → IDLE.
- Accept, in IDLE or DONE with Start=1:
  - A_reg←A, B_reg←B.
  - acc←0, cnt←0.
- RUN cycle i (cnt=i, i=0..3):
  - pp = A_reg & {4{B_reg[i]}}, produced by the `partial_product` instance.
  - acc ← acc + ({4'b0,pp} << i).
  - cnt ← cnt+1.
- Arithmetic:
  - 8-bit unsigned add; the maximum result 15×15=225 cannot overflow.
  - No sign handling.
  - No early termination on zero bits; latency is always fixed.
- Product = acc, driven continuously from the register.
- Operand changes:
  - A and B are ignored outside the accept cycle.
  - Changing A or B during RUN has no effect on the result.
- Start during RUN is ignored; there is no queueing.

## Timing
- Reset, rst_n=0 at a rising edge:
  - state←IDLE, Busy=0, Done=0, Product=8'h00.
  - cnt, A_reg and B_reg are cleared.
  - Reset has priority over Start and over any RUN step.
  - Reset mid-RUN aborts the operation; no Done is produced.
- Latency:
  - Start accepted at edge t0.
  - Accumulation occurs at edges t1..t4.
  - Done=1 and the final Product are visible in the cycle after t4, i.e. 4 cycles after the accept edge.
- Busy is high for exactly 4 cycles, beginning the cycle after the accept edge.
- Done is high for exactly one cycle. Busy and Done are never high together.
- Back-to-back: Start=1 during the DONE cycle is accepted.
  - The next result's Done follows 4 cycles later.
  - Throughput is one product per 5 cycles.
  - The previous Product remains valid through the DONE cycle only, then acc clears.
- Start held high continuously: a new multiply is accepted every DONE cycle.

## Structure
- Shared include `mult_defs.vh` holds:
  - OP_W=4, PROD_W=8, CNT_W=2.
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The encoding 2'd3 is illegal and must recover to IDLE.
- One sub-module: an instance of the existing `partial_product` (A_reg, B_reg[cnt], pp).
- The control FSM, counter, shifter and adder stay in the top module.

## Test plan
- Reset, then A=15, B=15, Start pulse → Busy for 4 cycles, then Done pulse with Product=225 (8'hE1).
- A=0, B=9 → Product=0; Done still arrives exactly 4 cycles after accept.
- A=13, B=11 → Product=143. During RUN, drive A=0 and B=0 and pulse Start → both ignored, Product=143.
- Back-to-back:
  - A=3, B=5 → Product=15.
  - Start with A=7, B=6 in the DONE cycle → second Done 5 cycles after the first, Product=42.
- Reset mid-run: rst_n=0 at the second RUN cycle of A=9, B=9 → next cycle Busy=0, Done=0, Product=0, state IDLE. No Done thereafter until a new Start.
- Exhaustive: all 256 A,B pairs, Start held high → each Done carries A×B, with no missed or duplicated Done.

Source files
------------

// File: rtl/partial_product_accumulator_pkg.sv
// Shared widths and FSM encoding for the sequential shift-add multiplier.
package partial_product_accumulator_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned CNT_W  = 2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OP_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/partial_product_accumulator_pp.sv
// Partial-product generator: multiplicand gated by a single multiplier bit.
module partial_product
    import partial_product_accumulator_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic            b,
    output logic [OP_W-1:0] pp
);

    assign pp = a & {OP_W{b}};

endmodule

// File: rtl/partial_product_accumulator.sv
// Iterative 4x4 unsigned multiplier: one multiplier bit per cycle, shift-add into acc.
module partial_product_accumulator
    import partial_product_accumulator_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    output logic              Busy,
    output logic              Done,
    output logic [PROD_W-1:0] Product
);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic [OP_W-1:0]     a_reg;
    logic [OP_W-1:0]     b_reg;
    logic [CNT_W-1:0]    cnt;
    logic [PROD_W-1:0]   acc;
    logic [OP_W-1:0]     pp;

    partial_product u_pp (
        .a  (a_reg),
        .b  (b_reg[cnt]),
        .pp (pp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt == LAST_BIT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            // unused encoding falls back to IDLE
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B;
            cnt   <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            acc <= acc + (PROD_W'(pp) << cnt);
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign Product = acc;

endmodule

// File: tb/tb_partial_product_accumulator.sv
// Self-checking bench for partial_product_accumulator against an arithmetic model.
module tb_partial_product_accumulator;

    logic       clk;
    logic       rst_n;
    logic       Start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Busy;
    logic       Done;
    logic [7:0] Product;

    int n_checks = 0;
    int n_fail   = 0;

    partial_product_accumulator dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        bit         disturb;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One complete multiply; optionally pokes Start/A/B during RUN.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                          input bit disturb, input string tag);
        int lat;
        int busy_n;
        bit seen;
        @(negedge clk);
        Start = 1'b1; A = a; B = b;
        @(negedge clk);
        Start = disturb;
        if (disturb) begin
            A = '0; B = '0;
        end else begin
            A = 4'($urandom); B = 4'($urandom);
        end
        lat = 0; busy_n = 0; seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (Done) begin
                seen = 1;
                break;
            end
            if (Busy) busy_n++;
            @(negedge clk);
            Start = 1'b0;
            lat++;
        end
        check($sformatf("%s seen_done", tag), 32'(seen), 32'd1);
        check($sformatf("%s latency", tag), 32'(lat), 32'd4);
        check($sformatf("%s busy_cycles", tag), 32'(busy_n), 32'd4);
        check($sformatf("%s product", tag), 32'(Product), 32'(exp));
        check($sformatf("%s busy_with_done", tag), 32'(Busy), 32'd0);
        @(negedge clk);
        check($sformatf("%s done_pulse", tag), 32'(Done), 32'd0);
        check($sformatf("%s product_hold", tag), 32'(Product), 32'(exp));
    endtask

    initial begin
        int gap;
        int cnt;
        int idx;
        int dones;
        int since;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] q[$];

        vecs[0] = '{a: 4'd15, b: 4'd15, exp: 8'd225, disturb: 1'b0};
        vecs[1] = '{a: 4'd0,  b: 4'd9,  exp: 8'd0,   disturb: 1'b0};
        vecs[2] = '{a: 4'd13, b: 4'd11, exp: 8'd143, disturb: 1'b1};
        vecs[3] = '{a: 4'd1,  b: 4'd1,  exp: 8'd1,   disturb: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd0,  exp: 8'd0,   disturb: 1'b1};
        vecs[5] = '{a: 4'd8,  b: 4'd8,  exp: 8'd64,  disturb: 1'b0};

        rst_n = 1'b0; Start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(Busy), 32'd0);
        check("reset done", 32'(Done), 32'd0);
        check("reset product", 32'(Product), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].disturb, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_op(ra, rb, 8'(int'(ra) * int'(rb)), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        // Back-to-back: second Start issued in the DONE cycle
        @(negedge clk);
        Start = 1'b1; A = 4'd3; B = 4'd5;
        @(negedge clk);
        Start = 1'b0;
        cnt = 0;
        while (!Done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b first done", 32'(Done), 32'd1);
        check("b2b first product", 32'(Product), 32'd15);
        Start = 1'b1; A = 4'd7; B = 4'd6;
        @(negedge clk);
        Start = 1'b0;
        check("b2b acc cleared", 32'(Product), 32'd0);
        check("b2b busy", 32'(Busy), 32'd1);
        gap = 1;
        while (!Done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("b2b gap", 32'(gap), 32'd5);
        check("b2b second product", 32'(Product), 32'd42);
        @(negedge clk);

        // Reset asserted for the second RUN edge aborts the multiply
        Start = 1'b1; A = 4'd9; B = 4'd9;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        check("abort partial product", 32'(Product), 32'd9);
        check("abort busy before", 32'(Busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(Busy), 32'd0);
        check("abort done", 32'(Done), 32'd0);
        check("abort product", 32'(Product), 32'd0);
        rst_n = 1'b1;
        cnt = 0; gap = 0;
        repeat (12) begin
            @(negedge clk);
            if (Done) cnt++;
            if (Busy) gap++;
        end
        check("abort no done", 32'(cnt), 32'd0);
        check("abort stays idle", 32'(gap), 32'd0);

        // Exhaustive with Start held high; queue of expected products
        Start = 1'b1; A = 4'd0; B = 4'd0;
        q.push_back(8'd0);
        idx = 1; dones = 0; since = 0;
        for (int cyc = 0; cyc < 256 * 5 + 40 && dones < 256; cyc++) begin
            @(negedge clk);
            since++;
            if (Done) begin
                dones++;
                check($sformatf("exh gap%0d", dones), 32'(since), 32'd5);
                since = 0;
                if (q.size() == 0) begin
                    check("exh extra done", 32'd1, 32'd0);
                end else begin
                    check($sformatf("exh product%0d", dones - 1), 32'(Product), 32'(q.pop_front()));
                end
                if (idx < 256) begin
                    A = 4'(idx >> 4);
                    B = 4'(idx & 15);
                    q.push_back(8'((idx >> 4) * (idx & 15)));
                    idx++;
                end else begin
                    Start = 1'b0;
                end
            end
        end
        check("exh done count", 32'(dones), 32'd256);
        Start = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (Done) cnt++;
        end
        check("exh no trailing done", 32'(cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
